// File: rtl/ir_freq_pkg.sv
// Shared widths, limits and FSM encoding for the IR carrier frequency meter.
package ir_freq_pkg;

  localparam int FREQ_W = 10;
  localparam logic [FREQ_W-1:0] FREQ_MAX = 10'd1023;

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Edge counters stick at FREQ_MAX instead of wrapping back to a small value.
  function automatic logic [FREQ_W-1:0] sat_inc(input logic [FREQ_W-1:0] v);
    return (v == FREQ_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ir_edge_detect.sv
// One IR channel: 2-FF synchronizer, optional deglitch (IR_FREQ_DEGLITCH_EN),
// and a registered single-cycle rising-edge pulse.
module ir_edge_detect #(
  parameter int MIN_PULSE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  if (MIN_PULSE < 1) begin : g_bad_min_pulse
    $error("ir_edge_detect: MIN_PULSE must be at least 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef IR_FREQ_DEGLITCH_EN
  localparam int HOLD_W = $clog2(MIN_PULSE + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_PULSE - 1);

  logic [HOLD_W-1:0] hold;

  // The filtered level follows only after MIN_PULSE consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      hold  <= '0;
    end else if (sync2 == level) begin
      hold <= '0;
    end else if (hold == HOLD_LAST) begin
      level <= sync2;
      hold  <= '0;
    end else begin
      hold <= hold + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/ir_freq_meter.sv
// Gated edge counting on two IR channels with window-to-window agreement before
// publishing; build with IR_FREQ_DEGLITCH_EN to add the per-channel pulse filter.
module ir_freq_meter
  import ir_freq_pkg::*;
#(
  parameter int GATE_CYCLES    = 100_000_000,
  parameter int STABLE_WINDOWS = 2,
  parameter int TOL            = 8,
  parameter int MIN_PULSE      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        IR,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid,
  output logic              stable,
  output logic              active_ch
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 2;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam int AW = 4;
  localparam logic [AW-1:0] AGREE_MAX = AW'(STABLE_WINDOWS);
  localparam logic [31:0] TOL_U = 32'(TOL);

  if (GATE_CYCLES < 4 || STABLE_WINDOWS < 1 || STABLE_WINDOWS > 15) begin : g_bad_params
    $error("ir_freq_meter: GATE_CYCLES >= 4 and STABLE_WINDOWS in 1..15 required");
  end

  logic [1:0]                   rise;
  logic [1:0][FREQ_W-1:0]       cnt;
  logic [GW-1:0]                gate;
  logic                         tc;
  state_t                       state;
  logic [FREQ_W-1:0]            cur;
  logic                         cur_ch;
  logic [FREQ_W-1:0]            prev;
  logic [AW-1:0]                agree;
  logic signed [FREQ_W:0]       diff;
  logic [FREQ_W:0]              abs_diff;
  logic                         within_tol;
  logic [AW-1:0]                agree_inc;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    ir_edge_detect #(
      .MIN_PULSE(MIN_PULSE)
    ) u_edge (
      .clk (clk),
      .rst (reset),
      .din (IR[c]),
      .rise(rise[c])
    );
  end

  assign tc = (gate == GATE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate <= '0;
    end else if (tc) begin
      gate <= '0;
    end else begin
      gate <= gate + 1'b1;
    end
  end

  // An edge on the TC cycle seeds the next window rather than being dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (tc) begin
          cnt[c] <= rise[c] ? FREQ_W'(1) : '0;
        end else if (rise[c]) begin
          cnt[c] <= sat_inc(cnt[c]);
        end
      end
    end
  end

  assign diff       = $signed({1'b0, cur}) - $signed({1'b0, prev});
  assign abs_diff   = diff[FREQ_W] ? 11'(-diff) : 11'(diff);
  assign within_tol = ({21'd0, abs_diff} <= TOL_U);
  assign agree_inc  = (agree >= AGREE_MAX) ? AGREE_MAX : agree + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COUNT;
      cur        <= '0;
      cur_ch     <= 1'b0;
      prev       <= '0;
      agree      <= '0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      stable     <= 1'b0;
      active_ch  <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      unique case (state)
        COUNT: begin
          if (tc) begin
            // Channel 0 wins ties; channel 1 only when strictly larger.
            cur    <= (cnt[1] > cnt[0]) ? cnt[1] : cnt[0];
            cur_ch <= (cnt[1] > cnt[0]);
            state  <= EVAL;
          end
        end
        EVAL: begin
          agree <= within_tol ? agree_inc : AW'(1);
          prev  <= cur;
          state <= UPDATE;
        end
        UPDATE: begin
          if (cur == '0) begin
            freq_out   <= '0;
            stable     <= 1'b0;
            freq_valid <= 1'b1;
          end else if (agree >= AGREE_MAX) begin
            freq_out   <= cur;
            active_ch  <= cur_ch;
            stable     <= 1'b1;
            freq_valid <= 1'b1;
          end else begin
            stable <= 1'b0;
          end
          state <= COUNT;
        end
        default: state <= COUNT;
      endcase
    end
  end

endmodule
